// File: rtl/cnn_pkg.sv
// Types and helpers shared by the CNN datapath stages (ReLU, pooling, conv).
package cnn_pkg;

    localparam int unsigned CNN_DATA_W = 32;

    typedef logic signed [CNN_DATA_W-1:0] pixel_t;

    function automatic pixel_t smax(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer for the pooling stage: single write port, combinational read, no storage reset.
module pool_line_buf #(
    parameter int unsigned DEPTH  = 14,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// 2x2 stride-2 pooling over a row-major valid-qualified pixel stream, one channel per frame.
// Max pooling by default; define MAXPOOL2X2_AVG_EN to build average pooling instead.
module maxpool2x2_stream
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_W = CNN_DATA_W,
    parameter int unsigned IMG_W  = 28,
    parameter int unsigned IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] d_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] d_out,
    output logic              frame_done
);

    localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned LB_DEPTH = IMG_W / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef MAXPOOL2X2_AVG_EN
    localparam int unsigned LB_W     = DATA_W + 1;
`else
    localparam int unsigned LB_W     = DATA_W;
`endif

    if (((IMG_W % 2) != 0) || (IMG_W < 2)) begin : g_bad_img_w
        $error("maxpool2x2_stream: IMG_W must be even and >= 2");
    end
    if (((IMG_H % 2) != 0) || (IMG_H < 2)) begin : g_bad_img_h
        $error("maxpool2x2_stream: IMG_H must be even and >= 2");
    end

    typedef enum logic {
        ROW_EVEN = 1'b0,
        ROW_ODD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic              out_valid_d;
    logic [DATA_W-1:0] d_out_d;
    logic              frame_done_d;

    logic              last_col;
    logic              last_row;
    logic              lb_we;
    logic [LB_AW-1:0]  lb_addr;
    logic [LB_W-1:0]   lb_rd;
    logic [LB_W-1:0]   h;
    logic [DATA_W-1:0] result;

    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));
    // Horizontal pair index; even rows write it, odd rows read it, never the same cycle.
    assign lb_addr  = LB_AW'(col_q >> 1);

`ifdef MAXPOOL2X2_AVG_EN
    logic [DATA_W+1:0] sum;

    // Window sum carried at full precision, then floor-divided by 4.
    assign h      = {pair_q[DATA_W-1], pair_q} + {d_in[DATA_W-1], d_in};
    assign sum    = {lb_rd[LB_W-1], lb_rd} + {h[LB_W-1], h};
    assign result = sum[DATA_W+1:2];
`else
    if (DATA_W == CNN_DATA_W) begin : g_pkg_max
        assign h      = smax(pixel_t'(pair_q), pixel_t'(d_in));
        assign result = smax(pixel_t'(lb_rd), pixel_t'(h));
    end else begin : g_gen_max
        assign h      = ($signed(pair_q) > $signed(d_in)) ? pair_q : d_in;
        assign result = ($signed(lb_rd) > $signed(h)) ? lb_rd : h;
    end
`endif

    pool_line_buf #(
        .DEPTH  (LB_DEPTH),
        .WIDTH  (LB_W),
        .ADDR_W (LB_AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (h),
        .raddr (lb_addr),
        .rdata (lb_rd)
    );

    // Next-state, counters and output decode; everything holds on bubble cycles.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        pair_d       = pair_q;
        lb_we        = 1'b0;
        out_valid_d  = 1'b0;
        d_out_d      = d_out;
        frame_done_d = 1'b0;

        if (in_valid) begin
            col_d = last_col ? '0 : col_q + COL_W'(1);
            if (last_col) begin
                row_d = last_row ? '0 : row_q + ROW_W'(1);
            end
            if (!col_q[0]) begin
                pair_d = d_in;
            end

            case (state_q)
                ROW_EVEN: begin
                    lb_we = col_q[0];
                    if (last_col) begin
                        state_d = ROW_ODD;
                    end
                end
                ROW_ODD: begin
                    if (col_q[0]) begin
                        out_valid_d  = 1'b1;
                        d_out_d      = result;
                        frame_done_d = last_col && last_row;
                    end
                    if (last_col) begin
                        state_d = ROW_EVEN;
                    end
                end
                default: state_d = ROW_EVEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ROW_EVEN;
            col_q      <= '0;
            row_q      <= '0;
            pair_q     <= '0;
            out_valid  <= 1'b0;
            d_out      <= '0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pair_q     <= pair_d;
            out_valid  <= out_valid_d;
            d_out      <= d_out_d;
            frame_done <= frame_done_d;
        end
    end

endmodule
